result_stack: RTL and testbench

- Output-side LIFO that drains results produced by the stack core toward the host.
- It is the reader-facing counterpart of the input stack that feeds the core.
  - Core side: pushes 16-bit results.
  - Host side: pops them through a valid/ready handshake.
  - Host side: can also read any occupied slot by absolute position.
- Sits between the core's top-of-stack output and the external host bus.

---
 rtl/result_stack.sv | 144 ++++++++++++++
 tb/tb_result_stack.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stack.sv
// Output-side LIFO that drains core results to the host. Pops use a valid/ready
// handshake, and any occupied slot can be read by position. Optional macro RESULT_STACK_ERR_EN adds ovf/err_cnt.
module result_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic [AW-1:0]     peek_addr,
  input  logic              peek_en,
  output logic [DATA_W-1:0] peek_data,
  output logic              peek_hit
`ifdef RESULT_STACK_ERR_EN
  ,
  output logic              ovf,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPLACE,
    OP_PUSH,
    OP_DROP,
    OP_POP
  } op_e;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_sp;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_peek_data;
  logic              r_peek_hit;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic [AW-1:0]     w_top_idx;
  logic [AW-1:0]     w_below_idx;
  logic [AW-1:0]     w_free_idx;
  op_e               w_op;

  assign w_empty     = (r_sp == '0);
  assign w_full      = (r_sp == FULL_CNT);
  assign w_pop       = !w_empty && rd_ready;
  assign w_free_idx  = r_sp[AW-1:0];
  assign w_top_idx   = r_sp[AW-1:0] - AW'(1);
  assign w_below_idx = r_sp[AW-1:0] - AW'(2);

  // Edge priority: flush > push&pop > push > pop.
  always_comb begin
    // NOTE: default first, so every path through the block assigns w_op and no latch is inferred.
    w_op = OP_IDLE;
    if (flush)             w_op = OP_FLUSH;
    else if (push && w_pop) w_op = OP_REPLACE;
    else if (push)          w_op = w_full ? OP_DROP : OP_PUSH;
    else if (w_pop)         w_op = OP_POP;
  end

  // NOTE: the storage array has no reset; its contents are don't-care until written, so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_op == OP_REPLACE)   r_mem[w_top_idx]  <= push_data;
    else if (w_op == OP_PUSH) r_mem[w_free_idx] <= push_data;
  end

  // NOTE: non-blocking assignments, so peek and rd_data read pre-write memory contents on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp      <= '0;
      r_rd_data <= '0;
    end else begin
      case (w_op)
        OP_FLUSH: begin
          r_sp      <= '0;
          r_rd_data <= '0;
        end
        OP_REPLACE: r_rd_data <= push_data;
        OP_PUSH: begin
          r_sp      <= r_sp + (AW+1)'(1);
          r_rd_data <= push_data;
        end
        OP_POP: begin
          r_sp      <= r_sp - (AW+1)'(1);
          r_rd_data <= (r_sp == (AW+1)'(1)) ? '0 : r_mem[w_below_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peek_data <= '0;
      r_peek_hit  <= 1'b0;
    end else if (peek_en) begin
      r_peek_hit  <= ({1'b0, peek_addr} < r_sp);
      r_peek_data <= ({1'b0, peek_addr} < r_sp) ? r_mem[peek_addr] : '0;
    end else begin
      r_peek_hit  <= 1'b0;
    end
  end

`ifdef RESULT_STACK_ERR_EN
  logic       r_ovf;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_op == OP_FLUSH) begin
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_op == OP_DROP) begin
      r_ovf <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign ovf     = r_ovf;
  assign err_cnt = r_err_cnt;
`endif

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_sp;
  assign rd_valid  = !w_empty;
  assign rd_data   = r_rd_data;
  assign peek_data = r_peek_data;
  assign peek_hit  = r_peek_hit;

endmodule

// File: tb/tb_result_stack.sv
// Directed self-checking bench for result_stack; each scenario task does its own comparisons.
module tb_result_stack;

  logic        clk;
  logic        rst;
  logic        push;
  logic [15:0] push_data;
  logic        flush;
  logic        full;
  logic        empty;
  logic [5:0]  count;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [4:0]  peek_addr;
  logic        peek_en;
  logic [15:0] peek_data;
  logic        peek_hit;
`ifdef RESULT_STACK_ERR_EN
  logic        ovf;
  logic [7:0]  err_cnt;
`endif

  int n_pass;
  int n_total;

  result_stack dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .peek_addr (peek_addr),
    .peek_en   (peek_en),
    .peek_data (peek_data),
    .peek_hit  (peek_hit)
`ifdef RESULT_STACK_ERR_EN
    ,
    .ovf       (ovf),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push      = 1'b0;
    push_data = '0;
    flush     = 1'b0;
    rd_ready  = 1'b0;
    peek_en   = 1'b0;
    peek_addr = '0;
  endtask

  task automatic do_push(input logic [15:0] d);
    push      = 1'b1;
    push_data = d;
    cycle();
    push      = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    n_total++; if (empty !== 1'b1)     $display("FAIL reset_empty got=%b exp=1", empty);       else n_pass++;
    n_total++; if (full !== 1'b0)      $display("FAIL reset_full got=%b exp=0", full);         else n_pass++;
    n_total++; if (count !== 6'd0)     $display("FAIL reset_count got=%0d exp=0", count);      else n_pass++;
    n_total++; if (rd_valid !== 1'b0)  $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else n_pass++;
    n_total++; if (rd_data !== 16'h0)  $display("FAIL reset_rd_data got=%h exp=0000", rd_data); else n_pass++;
    n_total++; if (peek_hit !== 1'b0)  $display("FAIL reset_peek_hit got=%b exp=0", peek_hit); else n_pass++;
    n_total++; if (peek_data !== 16'h0) $display("FAIL reset_peek_data got=%h exp=0000", peek_data); else n_pass++;
  endtask

  task automatic test_push_pop();
    logic [15:0] exp_pop [3];
    exp_pop[0] = 16'h0033; exp_pop[1] = 16'h0022; exp_pop[2] = 16'h0011;
    do_push(16'h0011);
    do_push(16'h0022);
    do_push(16'h0033);
    n_total++; if (count !== 6'd3)       $display("FAIL pp_count got=%0d exp=3", count);        else n_pass++;
    n_total++; if (rd_data !== 16'h0033) $display("FAIL pp_top got=%h exp=0033", rd_data);     else n_pass++;
    n_total++; if (rd_valid !== 1'b1)    $display("FAIL pp_rd_valid got=%b exp=1", rd_valid);  else n_pass++;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (rd_data !== exp_pop[i]) $display("FAIL pp_pop%0d got=%h exp=%h", i, rd_data, exp_pop[i]);
      else n_pass++;
      cycle();
    end
    rd_ready = 1'b0;
    n_total++; if (empty !== 1'b1)     $display("FAIL pp_empty got=%b exp=1", empty);        else n_pass++;
    n_total++; if (rd_data !== 16'h0)  $display("FAIL pp_rd_zero got=%h exp=0000", rd_data); else n_pass++;
    n_total++; if (rd_valid !== 1'b0)  $display("FAIL pp_valid_low got=%b exp=0", rd_valid); else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) do_push(16'h0100 + 16'(i));
    n_total++; if (full !== 1'b1)        $display("FAIL fill_full got=%b exp=1", full);         else n_pass++;
    n_total++; if (count !== 6'd32)      $display("FAIL fill_count got=%0d exp=32", count);     else n_pass++;
    n_total++; if (rd_data !== 16'h011F) $display("FAIL fill_top got=%h exp=011f", rd_data);    else n_pass++;
    do_push(16'hBEEF);
    n_total++; if (count !== 6'd32)      $display("FAIL drop_count got=%0d exp=32", count);     else n_pass++;
    n_total++; if (rd_data !== 16'h011F) $display("FAIL drop_top got=%h exp=011f", rd_data);    else n_pass++;
`ifdef RESULT_STACK_ERR_EN
    n_total++; if (ovf !== 1'b1)     $display("FAIL drop_ovf got=%b exp=1", ovf);          else n_pass++;
    n_total++; if (err_cnt !== 8'd1) $display("FAIL drop_err_cnt got=%0d exp=1", err_cnt); else n_pass++;
`endif
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
    n_total++; if (count !== 6'd31)      $display("FAIL ovf_pop_count got=%0d exp=31", count);  else n_pass++;
    n_total++; if (rd_data !== 16'h011E) $display("FAIL ovf_pop_top got=%h exp=011e", rd_data); else n_pass++;
    do_flush();
    n_total++; if (count !== 6'd0)       $display("FAIL fill_flush got=%0d exp=0", count);      else n_pass++;
`ifdef RESULT_STACK_ERR_EN
    n_total++; if (ovf !== 1'b0)     $display("FAIL flush_ovf got=%b exp=0", ovf);          else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL flush_err_cnt got=%0d exp=0", err_cnt); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    do_push(16'h00A0);
    do_push(16'h00B0);
    push      = 1'b1;
    push_data = 16'h00C0;
    rd_ready  = 1'b1;
    cycle();
    push      = 1'b0;
    n_total++; if (count !== 6'd2)       $display("FAIL b2b_count got=%0d exp=2", count);    else n_pass++;
    n_total++; if (rd_data !== 16'h00C0) $display("FAIL b2b_top got=%h exp=00c0", rd_data);  else n_pass++;
    cycle();
    n_total++; if (count !== 6'd1)       $display("FAIL b2b_pop_count got=%0d exp=1", count);   else n_pass++;
    n_total++; if (rd_data !== 16'h00A0) $display("FAIL b2b_pop_top got=%h exp=00a0", rd_data); else n_pass++;
    cycle();
    cycle();
    rd_ready = 1'b0;
    n_total++; if (count !== 6'd0)   $display("FAIL underflow_count got=%0d exp=0", count);   else n_pass++;
    n_total++; if (empty !== 1'b1)   $display("FAIL underflow_empty got=%b exp=1", empty);    else n_pass++;
    n_total++; if (rd_data !== 16'h0) $display("FAIL underflow_rd got=%h exp=0000", rd_data); else n_pass++;
  endtask

  task automatic test_peek();
    for (int i = 1; i <= 4; i++) do_push(16'h0400 + 16'(i));
    peek_en   = 1'b1;
    peek_addr = 5'd2;
    cycle();
    n_total++; if (peek_data !== 16'h0403) $display("FAIL peek2_data got=%h exp=0403", peek_data); else n_pass++;
    n_total++; if (peek_hit !== 1'b1)      $display("FAIL peek2_hit got=%b exp=1", peek_hit);      else n_pass++;
    peek_addr = 5'd4;
    cycle();
    n_total++; if (peek_data !== 16'h0)  $display("FAIL peek4_data got=%h exp=0000", peek_data); else n_pass++;
    n_total++; if (peek_hit !== 1'b0)    $display("FAIL peek4_hit got=%b exp=0", peek_hit);      else n_pass++;
    peek_addr = 5'd3;
    cycle();
    peek_en = 1'b0;
    cycle();
    n_total++; if (peek_hit !== 1'b0)      $display("FAIL peek_idle_hit got=%b exp=0", peek_hit);       else n_pass++;
    n_total++; if (peek_data !== 16'h0404) $display("FAIL peek_hold got=%h exp=0404", peek_data);       else n_pass++;
    n_total++; if (count !== 6'd4)         $display("FAIL peek_count got=%0d exp=4", count);            else n_pass++;
    // Overwrite the top slot while peeking it: the peek must see the old word.
    peek_en   = 1'b1;
    peek_addr = 5'd3;
    push      = 1'b1;
    push_data = 16'h0999;
    rd_ready  = 1'b1;
    cycle();
    push     = 1'b0;
    rd_ready = 1'b0;
    n_total++; if (peek_data !== 16'h0404) $display("FAIL peek_old got=%h exp=0404", peek_data); else n_pass++;
    n_total++; if (rd_data !== 16'h0999)   $display("FAIL peek_rep_top got=%h exp=0999", rd_data); else n_pass++;
    cycle();
    peek_en = 1'b0;
    n_total++; if (peek_data !== 16'h0999) $display("FAIL peek_new got=%h exp=0999", peek_data); else n_pass++;
    do_flush();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) do_push(16'h0500 + 16'(i));
    n_total++; if (count !== 6'd5) $display("FAIL flush_pre_count got=%0d exp=5", count); else n_pass++;
    flush     = 1'b1;
    push      = 1'b1;
    push_data = 16'h1234;
    cycle();
    flush = 1'b0;
    push  = 1'b0;
    n_total++; if (count !== 6'd0)     $display("FAIL flush_count got=%0d exp=0", count);     else n_pass++;
    n_total++; if (empty !== 1'b1)     $display("FAIL flush_empty got=%b exp=1", empty);      else n_pass++;
    n_total++; if (rd_valid !== 1'b0)  $display("FAIL flush_valid got=%b exp=0", rd_valid);   else n_pass++;
    n_total++; if (rd_data !== 16'h0)  $display("FAIL flush_rd got=%h exp=0000", rd_data);    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_push(16'h0061);
    push      = 1'b1;
    push_data = 16'h0062;
    peek_en   = 1'b1;
    peek_addr = 5'd0;
    cycle();
    n_total++; if (peek_hit !== 1'b1)      $display("FAIL ar_pre_hit got=%b exp=1", peek_hit);      else n_pass++;
    n_total++; if (peek_data !== 16'h0061) $display("FAIL ar_pre_data got=%h exp=0061", peek_data); else n_pass++;
    push_data = 16'h0063;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (count !== 6'd0)      $display("FAIL ar_count got=%0d exp=0", count);        else n_pass++;
    n_total++; if (empty !== 1'b1)      $display("FAIL ar_empty got=%b exp=1", empty);         else n_pass++;
    n_total++; if (rd_valid !== 1'b0)   $display("FAIL ar_valid got=%b exp=0", rd_valid);      else n_pass++;
    n_total++; if (rd_data !== 16'h0)   $display("FAIL ar_rd got=%h exp=0000", rd_data);       else n_pass++;
    n_total++; if (peek_hit !== 1'b0)   $display("FAIL ar_hit got=%b exp=0", peek_hit);        else n_pass++;
    n_total++; if (peek_data !== 16'h0) $display("FAIL ar_peek got=%h exp=0000", peek_data);   else n_pass++;
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    cycle();
    n_total++; if (count !== 6'd0) $display("FAIL ar_after_count got=%0d exp=0", count); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    test_reset();
    test_push_pop();
    test_fill();
    test_back_to_back();
    test_peek();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
